// File: rtl/runway_monitor_if.sv
// runway_monitor_if: lamp-bus sample inputs and decoded wind/error outputs of the runway monitor
interface runway_monitor_if #(parameter int ERR_W = 4);
    logic             sample_en;
    logic [2:0]       ledr;
    logic [1:0]       wind;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    modport master (output sample_en, ledr, input wind, locked, err, err_count);
    modport slave  (input sample_en, ledr, output wind, locked, err, err_count);
endinterface

// File: rtl/runway_monitor.sv
// runway_monitor: decodes the 3-lamp runway pattern into a wind mode, flags illegal values/steps
module runway_monitor #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 4
) (
    input  logic            clk,
    input  logic            reset,
    runway_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, TRACK, LOCKED} state_t;
    localparam logic [3:0]       LC      = 4'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state, state_n;
    logic [2:0]       prev, prev_n;
    logic [1:0]       cand, cand_n, wind, wind_n, cls;
    logic [3:0]       run, run_n;
    logic             locked, locked_n, err, err_n, legal;
    logic [ERR_W-1:0] cnt, cnt_n;

    function automatic logic [1:0] classify(input logic [2:0] p, input logic [2:0] c);
        case ({p, c})
            6'b101_010, 6'b010_101:             return 2'b00;
            6'b001_010, 6'b010_100, 6'b100_001: return 2'b01;
            6'b100_010, 6'b010_001, 6'b001_100: return 2'b10;
            default:                            return 2'b11;
        endcase
    endfunction

    assign legal = bus.ledr inside {3'b101, 3'b010, 3'b001, 3'b100};
    assign cls   = classify(prev, bus.ledr);

    always_comb begin
        state_n  = state;
        prev_n   = prev;
        cand_n   = cand;
        run_n    = run;
        wind_n   = wind;
        locked_n = locked;
        err_n    = 1'b0;
        cnt_n    = cnt;
        if (bus.sample_en) begin
            if (!legal || (state != IDLE && cls == 2'b11)) begin
                err_n    = 1'b1;
                cnt_n    = (cnt == ERR_MAX) ? cnt : cnt + 1'b1;
                locked_n = 1'b0;
                wind_n   = 2'b11;
                state_n  = legal ? SEARCH : IDLE;
            end else if (state == IDLE) begin
                state_n = SEARCH;
            end else if (state == SEARCH || (state == TRACK && cls != cand)) begin
                // a class change while tracking restarts the run rather than flagging an error
                cand_n   = cls;
                run_n    = 4'd1;
                state_n  = (LC == 4'd1) ? LOCKED : TRACK;
                wind_n   = (LC == 4'd1) ? cls : wind;
                locked_n = (LC == 4'd1);
            end else if (state == TRACK) begin
                run_n = run + 4'd1;
                if (run + 4'd1 >= LC) begin
                    state_n  = LOCKED;
                    wind_n   = cand;
                    locked_n = 1'b1;
                end
            end else if (cls != wind) begin
                locked_n = 1'b0;
                wind_n   = 2'b11;
                cand_n   = cls;
                run_n    = 4'd1;
                state_n  = TRACK;
            end
            if (legal) prev_n = bus.ledr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            prev   <= 3'b000;
            cand   <= 2'b11;
            run    <= 4'd0;
            wind   <= 2'b11;
            locked <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            prev   <= prev_n;
            cand   <= cand_n;
            run    <= run_n;
            wind   <= wind_n;
            locked <= locked_n;
            err    <= err_n;
            cnt    <= cnt_n;
        end
    end

    assign bus.wind      = wind;
    assign bus.locked    = locked;
    assign bus.err       = err;
    assign bus.err_count = cnt;
endmodule

// File: tb/tb_runway_monitor.sv
// tb_runway_monitor: directed lamp sequences; expected outputs queued by stimulus, checked by a monitor
module tb_runway_monitor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    runway_monitor_if #(.ERR_W(4)) bus ();
    runway_monitor #(.LOCK_COUNT(3), .ERR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [1:0] w;
        logic       l;
        logic       e;
        logic [3:0] c;
    } exp_t;

    exp_t sb[$];
    int   tq[$];
    int   checks = 0;
    int   failures = 0;
    int   nstep = 0;

    function automatic exp_t now_out();
        return '{bus.wind, bus.locked, bus.err, bus.err_count};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got wind=%b locked=%b err=%b cnt=%0d want wind=%b locked=%b err=%b cnt=%0d",
                     name, got.w, got.l, got.e, got.c, want.w, want.l, want.e, want.c);
        end
    endtask

    task automatic step(input logic en, input logic [2:0] l, input logic [1:0] w,
                        input logic lk, input logic e, input logic [3:0] c);
        @(negedge clk);
        bus.sample_en = en;
        bus.ledr      = l;
        nstep++;
        sb.push_back('{w, lk, e, c});
        tq.push_back(nstep);
    endtask

    task automatic s(input logic [2:0] l, input logic [1:0] w, input logic lk, input logic e, input logic [3:0] c);
        step(1'b1, l, w, lk, e, c);
    endtask

    task automatic g(input logic [2:0] l, input logic [1:0] w, input logic lk, input logic e, input logic [3:0] c);
        step(1'b0, l, w, lk, e, c);
    endtask

    task automatic rst_pulse(input string name);
        @(negedge clk);
        bus.sample_en = 1'b0;
        #2 reset = 1'b0;
        #1 check(name, now_out(), '{2'b11, 1'b0, 1'b0, 4'd0});
        @(negedge clk);
        reset = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   t;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tq.pop_front();
            #1 check($sformatf("step%0d", t), now_out(), e);
        end
    end

    initial begin
        bus.sample_en = 1'b0;
        bus.ledr      = 3'b000;
        #12 check("reset_state", now_out(), '{2'b11, 1'b0, 1'b0, 4'd0});
        @(negedge clk);
        reset = 1'b1;
        // calm lock, then illegal value and re-seed
        s(3'b101, 2'b11, 0, 0, 0);
        s(3'b010, 2'b11, 0, 0, 0);
        s(3'b101, 2'b11, 0, 0, 0);
        s(3'b010, 2'b00, 1, 0, 0);
        s(3'b111, 2'b11, 0, 1, 1);
        g(3'b101, 2'b11, 0, 0, 1);
        s(3'b101, 2'b11, 0, 0, 1);
        s(3'b010, 2'b11, 0, 0, 1);
        // right-to-left lock, then mode change to left-to-right
        rst_pulse("reset_t2");
        s(3'b001, 2'b11, 0, 0, 0);
        s(3'b010, 2'b11, 0, 0, 0);
        s(3'b100, 2'b11, 0, 0, 0);
        s(3'b001, 2'b01, 1, 0, 0);
        s(3'b010, 2'b01, 1, 0, 0);
        s(3'b001, 2'b11, 0, 0, 0);
        s(3'b100, 2'b11, 0, 0, 0);
        s(3'b010, 2'b10, 1, 0, 0);
        // illegal transition, then right-to-left lock
        rst_pulse("reset_t4");
        s(3'b101, 2'b11, 0, 0, 0);
        s(3'b100, 2'b11, 0, 1, 1);
        s(3'b001, 2'b11, 0, 0, 1);
        s(3'b010, 2'b11, 0, 0, 1);
        s(3'b100, 2'b01, 1, 0, 1);
        // held value: one seed then 19 errors, count saturates at 15
        rst_pulse("reset_t5");
        s(3'b010, 2'b11, 0, 0, 0);
        for (int i = 1; i <= 19; i++) s(3'b010, 2'b11, 0, 1, (i > 15) ? 4'd15 : 4'(i));
        // lock with saturated count, gated edges hold, async reset mid-cycle
        s(3'b101, 2'b11, 0, 0, 15);
        s(3'b010, 2'b11, 0, 0, 15);
        s(3'b101, 2'b00, 1, 0, 15);
        g(3'b010, 2'b00, 1, 0, 15);
        g(3'b111, 2'b00, 1, 0, 15);
        g(3'b000, 2'b00, 1, 0, 15);
        rst_pulse("async_reset_locked");
        s(3'b010, 2'b11, 0, 0, 0);
        s(3'b101, 2'b11, 0, 0, 0);
        // calm candidate interrupted by right-to-left restarts the run
        s(3'b010, 2'b11, 0, 0, 0);
        s(3'b100, 2'b11, 0, 0, 0);
        s(3'b001, 2'b11, 0, 0, 0);
        s(3'b010, 2'b01, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/runway_monitor.md
Name: runway_monitor

Overview:
- Receive-side checker for the 3-lamp runway light pattern generator.
- Samples the 3-bit lamp bus and decodes which wind mode the generator is running: calm, right-to-left or left-to-right.
- Flags illegal lamp values and illegal step sequences, and keeps a saturating error count.
- Used as a self-checking observer on the generator's LED output, and as a decoder when the lamp bus is driven from another board.

Parameters:
- LOCK_COUNT, 3, number of consecutive same-class legal transitions needed to declare lock (legal range 1..15).
- ERR_W, 4, width of err_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sample_en  input  1  when 1, ledr is sampled on this clock edge.
- ledr  input  3  lamp pattern under observation; bit 2 = left lamp, bit 0 = right lamp.
- wind  output  2  decoded mode: 00 calm, 01 right-to-left, 10 left-to-right, 11 unknown.
- locked  output  1  1 while the wind output is valid.
- err  output  1  one-cycle pulse on an illegal sample.
- err_count  output  ERR_W  saturating count of err pulses.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset = 0, all outputs take their reset values immediately, independent of clk: wind = 11, locked = 0, err = 0, err_count = 0, state = IDLE, prev = 000, run = 0.
- All outputs are registered. Response appears on the clock edge that samples ledr (sample_en = 1). Edges with sample_en = 0 hold all state, and err returns to 0.
- Legal lamp values: 101, 010, 001, 100. Illegal lamp values: 000, 011, 110, 111.
- Transition classes (prev -> current):
  - CALM: 101->010, 010->101.
  - RL: 001->010, 010->100, 100->001.
  - LR: 100->010, 010->001, 001->100.
  - Any other pair, including a hold (same value twice), is illegal.
- States:
  - IDLE: no valid prev.
  - SEARCH: prev valid, no class candidate.
  - TRACK: candidate class cand with run count 1..LOCK_COUNT-1.
  - LOCKED: class fixed.
- Transitions on a sampled edge:
  - IDLE, legal value: prev <= ledr, go to SEARCH. No class is evaluated.
  - SEARCH, legal transition of class C: cand = C, run = 1, go to TRACK. If LOCK_COUNT = 1, go directly to LOCKED instead.
  - TRACK, class C == cand: run++. When run reaches LOCK_COUNT, go to LOCKED with wind = C and locked = 1, both visible on that same edge.
  - TRACK, class C != cand: cand = C, run = 1, stay in TRACK. This is a mode change, not an error.
  - LOCKED, class C == wind: stay in LOCKED.
  - LOCKED, class C != wind: locked = 0, wind = 11, cand = C, run = 1, go to TRACK. No err.
  - Any state, illegal lamp value: err = 1, err_count++, locked = 0, wind = 11, go to IDLE.
  - SEARCH, TRACK or LOCKED, legal value but illegal transition: err = 1, err_count++, locked = 0, wind = 11, prev <= ledr, go to SEARCH.
- On every legal-value sample, prev <= ledr.
- err_count saturates at 2^ERR_W - 1 and never wraps.
- wind = 11 whenever locked = 0.
- Reset asserted mid-lock clears the block immediately. After release, the first sample only re-seeds prev.

Test Plan:
1. Calm lock, LOCK_COUNT = 3: reset, then sample 101, 010, 101, 010 → locked = 1 and wind = 00 on the 4th sample edge; err stays 0.
2. Right-to-left lock, then mode change: samples 001, 010, 100, 001 → wind = 01, locked = 1. Continue with 010, 001, 100, 010 → first mismatch (010->001, class LR) drops locked to 0 with wind = 11 and no err. Three LR transitions in total then give wind = 10, locked = 1.
3. Illegal value: while locked in calm, sample 111 → err pulses for one cycle, err_count = 1, locked = 0. Next sample 101 only re-seeds prev; no err.
4. Illegal transition: samples 101, 100 → err = 1, err_count = 1, state SEARCH with prev = 100. Then 001, 010, 100 (RL) → locked with wind = 01 on the 3rd transition.
5. Hold and saturation, ERR_W = 4: sample 010 twenty times in a row → 19 err pulses, err_count sticks at 15.
6. sample_en gating and async reset: toggling ledr with sample_en = 0 changes nothing. Asserting reset (0) between clock edges while locked clears wind to 11, locked to 0 and err_count to 0 before the next edge.
